multi_timer: RTL



---
 rtl/timer_pkg.sv | 23 ++
 rtl/timer_channel.sv | 70 +++++++
 rtl/multi_timer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Register map constants shared by the multi-channel timer and its channel slice.
package timer_pkg;

  // Global register word addresses
  localparam logic [4:0] PRESCALE_A = 5'h00;
  localparam logic [4:0] STATUS_A   = 5'h01;
  localparam logic [4:0] IRQEN_A    = 5'h02;

  // Channel c occupies CH_BASE + CH_STRIDE*c .. +3
  localparam logic [4:0] CH_BASE    = 5'h04;
  localparam int unsigned CH_STRIDE = 4;

  // Per-channel register offsets
  localparam logic [1:0] CTRL_O  = 2'd0;
  localparam logic [1:0] COUNT_O = 2'd1;
  localparam logic [1:0] CMP_O   = 2'd2;
  localparam logic [1:0] CAP_O   = 2'd3;

  // CTRL bit positions
  localparam int unsigned EN_B       = 0;
  localparam int unsigned PERIODIC_B = 1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/COUNT/COMPARE/CAPTURE registers and the match logic.
// A software write to CTRL or COUNT takes priority over a tick in the same cycle.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEF_CMP = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wr_ctrl,
  input  logic             wr_count,
  input  logic             wr_cmp,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cap_edge,
  output logic [1:0]       ctrl,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] compare,
  output logic [WIDTH-1:0] capture,
  output logic             hit
);

  logic [1:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cmp_q;
  logic [WIDTH-1:0] cap_q;

  // Next-state for CTRL/COUNT: software write, else tick-driven count/match
  always_comb begin
    ctrl_d  = ctrl_q;
    count_d = count_q;
    hit     = 1'b0;
    if (wr_ctrl || wr_count) begin
      if (wr_ctrl)  ctrl_d  = wdata[1:0];
      if (wr_count) count_d = wdata;
    end else if (tick && ctrl_q[EN_B]) begin
      if (count_q == cmp_q) begin
        hit     = 1'b1;
        count_d = '0;
        if (!ctrl_q[PERIODIC_B]) ctrl_d[EN_B] = 1'b0;
      end else begin
        // Wraps modulo 2^WIDTH if COMPARE was lowered below COUNT
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      count_q <= '0;
      cmp_q   <= WIDTH'(DEF_CMP);
      cap_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      if (wr_cmp)   cmp_q <= wdata;
      // Capture the pre-increment count
      if (cap_edge) cap_q <= count_q;
    end
  end

  assign ctrl    = ctrl_q;
  assign count   = count_q;
  assign compare = cmp_q;
  assign capture = cap_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel memory-mapped timer: shared prescaler, NCH channels, sticky W1C
// STATUS and a level irq. Define MULTI_TIMER_CAPTURE_EN to enable the per-channel
// cap_in capture path (synchronised rising edge -> CAPTURE and STATUS[NCH+c]).
module multi_timer
  import timer_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PS_W    = 8,
  parameter int unsigned DEF_CMP = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [4:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq,
  output logic [NCH-1:0]   match,
  input  logic [NCH-1:0]   cap_in
);

`ifdef MULTI_TIMER_CAPTURE_EN
  localparam int unsigned STAT_W = 2 * NCH;
`else
  localparam int unsigned STAT_W = NCH;
`endif

  logic [PS_W-1:0]   prescale_q, ps_cnt_q;
  logic              tick;
  logic [STAT_W-1:0] status_q, status_d, status_set, irq_en_q;
  logic [NCH-1:0]    hit, cap_edge;

  // Address decode for the channel window; CH_STRIDE of 4 makes addr bits [1:0]
  // the register offset and the remaining bits the channel index.
  logic [4:0] ch_off;
  logic [2:0] ch_idx;
  logic [1:0] reg_off;
  logic       ch_valid;

  assign ch_off   = addr - CH_BASE;
  assign ch_idx   = ch_off[4:2];
  assign reg_off  = ch_off[1:0];
  assign ch_valid = (addr >= CH_BASE) && (32'(ch_idx) < NCH);

  assign tick = (ps_cnt_q == prescale_q);

  // Prescaler: tick period is PRESCALE+1 clocks; a PRESCALE write restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_q <= '0;
      ps_cnt_q   <= '0;
    end else if (we && (addr == PRESCALE_A)) begin
      prescale_q <= wdata[PS_W-1:0];
      ps_cnt_q   <= '0;
    end else if (tick) begin
      ps_cnt_q   <= '0;
    end else begin
      ps_cnt_q   <= ps_cnt_q + PS_W'(1);
    end
  end

`ifdef MULTI_TIMER_CAPTURE_EN
  logic [NCH-1:0] cap_s1_q, cap_s2_q, cap_s3_q;

  // Two-flop synchroniser plus one delay stage for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_s1_q <= '0;
      cap_s2_q <= '0;
      cap_s3_q <= '0;
    end else begin
      cap_s1_q <= cap_in;
      cap_s2_q <= cap_s1_q;
      cap_s3_q <= cap_s2_q;
    end
  end

  assign cap_edge   = cap_s2_q & ~cap_s3_q;
  assign status_set = {cap_edge, hit};
`else
  logic unused_cap_in;
  assign unused_cap_in = ^cap_in;
  assign cap_edge      = '0;
  assign status_set    = hit;
`endif

  // STATUS: write-1-to-clear, with a same-cycle set taking priority
  always_comb begin
    status_d = status_q;
    if (we && (addr == STATUS_A)) status_d = status_d & ~wdata[STAT_W-1:0];
    status_d = status_d | status_set;
  end

  // STATUS and IRQ_EN registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
      irq_en_q <= '0;
    end else begin
      status_q <= status_d;
      if (we && (addr == IRQEN_A)) irq_en_q <= wdata[STAT_W-1:0];
    end
  end

  assign irq   = |(status_q & irq_en_q);
  assign match = status_q[NCH-1:0];

  // Per-channel read words, padded to 8 so the 3-bit index never leaves the array
  logic [WIDTH-1:0] ch_rd [8];

  for (genvar c = 0; c < 8; c++) begin : g_ch
    if (c < NCH) begin : g_inst
      logic             sel;
      logic [1:0]       ctrl;
      logic [WIDTH-1:0] count, compare, capture;

      assign sel = we && ch_valid && (ch_idx == 3'(c));

      timer_channel #(
        .WIDTH   (WIDTH),
        .DEF_CMP (DEF_CMP)
      ) u_channel (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .wr_ctrl  (sel && (reg_off == CTRL_O)),
        .wr_count (sel && (reg_off == COUNT_O)),
        .wr_cmp   (sel && (reg_off == CMP_O)),
        .wdata    (wdata),
        .cap_edge (cap_edge[c]),
        .ctrl     (ctrl),
        .count    (count),
        .compare  (compare),
        .capture  (capture),
        .hit      (hit[c])
      );

      assign ch_rd[c] = (reg_off == CTRL_O)  ? WIDTH'(ctrl) :
                        (reg_off == COUNT_O) ? count        :
                        (reg_off == CMP_O)   ? compare      : capture;
    end else begin : g_pad
      assign ch_rd[c] = '0;
    end
  end

  // Combinational read mux; unmapped addresses return 0
  always_comb begin
    rdata = '0;
    if (addr == PRESCALE_A)     rdata = WIDTH'(prescale_q);
    else if (addr == STATUS_A)  rdata = WIDTH'(status_q);
    else if (addr == IRQEN_A)   rdata = WIDTH'(irq_en_q);
    else if (ch_valid)          rdata = ch_rd[ch_idx];
  end

endmodule
